tod_counter: RTL and testbench

- Time-of-day counter that sits directly upstream of the calendar block.
- Counts hours:minutes:seconds from a periodic tick enable.
- On each midnight rollover it emits a single-cycle day_tick, which the calendar consumes to advance Day/Date/Month.
- Supports synchronous load of a new time, with range checking.

---
 rtl/tod_if.sv | 41 ++++
 rtl/tod_counter.sv | 123 ++++++++++++
 tb/tb_tod_counter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tod_if.sv
// tod_if: control, load and time-readout signals of the time-of-day counter.
// Optional alarm signals exist only when TOD_ALARM_EN is defined.
//   master: drives run/tick/load/ld_* (and al_* when enabled), observes the time.
//   slave : the counter itself; consumes the controls and presents the time.
interface tod_if;
    logic       run;
    logic       tick;
    logic       load;
    logic [4:0] ld_hh;
    logic [5:0] ld_mm;
    logic [5:0] ld_ss;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       day_tick;
    logic       load_err;
`ifdef TOD_ALARM_EN
    logic       al_en;
    logic [4:0] al_hh;
    logic [5:0] al_mm;
    logic       alarm;
`endif

    modport master (
        output run, tick, load, ld_hh, ld_mm, ld_ss,
`ifdef TOD_ALARM_EN
        output al_en, al_hh, al_mm,
        input  alarm,
`endif
        input  hh, mm, ss, day_tick, load_err
    );

    modport slave (
        input  run, tick, load, ld_hh, ld_mm, ld_ss,
`ifdef TOD_ALARM_EN
        input  al_en, al_hh, al_mm,
        output alarm,
`endif
        output hh, mm, ss, day_tick, load_err
    );
endinterface

// File: rtl/tod_counter.sv
// tod_counter: hours:minutes:seconds counter advanced by a prescaled tick.
// Emits a one-cycle day_tick on the 23:59:59 -> 00:00:00 rollover, which the
// downstream calendar uses to advance the date. Supports a range-checked load.
// Optional alarm comparator enabled by the macro TOD_ALARM_EN.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, clears all state
//   bus   - tod_if.slave: run, tick, load, ld_hh/ld_mm/ld_ss in;
//           hh/mm/ss, day_tick, load_err out (al_en/al_hh/al_mm in,
//           alarm out when TOD_ALARM_EN is defined)
// Parameter PRESCALE: qualified ticks per second, 1..1023.
module tod_counter #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    tod_if.slave bus
);

    localparam logic [9:0] PS_LAST = 10'(PRESCALE - 1);

    logic [9:0] presc;
    logic [4:0] hh_q;
    logic [5:0] mm_q;
    logic [5:0] ss_q;
    logic       day_tick_q;
    logic       load_err_q;

    logic [4:0] hh_nx;
    logic [5:0] mm_nx;
    logic [5:0] ss_nx;
    logic       wrap_nx;
    logic       qual;
    logic       load_ok;

    function automatic logic time_valid(input logic [4:0] h,
                                        input logic [5:0] m,
                                        input logic [5:0] s);
        return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
    endfunction

    // load has priority, so a coincident tick is discarded rather than counted
    assign qual    = bus.tick & bus.run & ~bus.load;
    assign load_ok = time_valid(bus.ld_hh, bus.ld_mm, bus.ld_ss);

    // Full carry chain in one cycle so no partial time is ever registered
    always_comb begin
        ss_nx   = ss_q + 6'd1;
        mm_nx   = mm_q;
        hh_nx   = hh_q;
        wrap_nx = 1'b0;
        if (ss_q == 6'd59) begin
            ss_nx = 6'd0;
            mm_nx = mm_q + 6'd1;
            if (mm_q == 6'd59) begin
                mm_nx = 6'd0;
                hh_nx = hh_q + 5'd1;
                if (hh_q == 5'd23) begin
                    hh_nx   = 5'd0;
                    wrap_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    hh_q  <= bus.ld_hh;
                    mm_q  <= bus.ld_mm;
                    ss_q  <= bus.ld_ss;
                    presc <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (qual) begin
                if (presc == PS_LAST) begin
                    presc      <= '0;
                    hh_q       <= hh_nx;
                    mm_q       <= mm_nx;
                    ss_q       <= ss_nx;
                    day_tick_q <= wrap_nx;
                end else begin
                    presc <= presc + 10'd1;
                end
            end
        end
    end

`ifdef TOD_ALARM_EN
    logic alarm_q;

    // Compare against the time being advanced into, so a load can never fire it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= qual && (presc == PS_LAST) && bus.al_en &&
                       (hh_nx == bus.al_hh) && (mm_nx == bus.al_mm) &&
                       (ss_nx == 6'd0);
        end
    end

    assign bus.alarm = alarm_q;
`endif

    assign bus.hh       = hh_q;
    assign bus.mm       = mm_q;
    assign bus.ss       = ss_q;
    assign bus.day_tick = day_tick_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_tod_counter.sv
module tb_tod_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tod_if ia ();
    tod_if ib ();

    tod_counter #(.PRESCALE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    tod_counter #(.PRESCALE(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int h, input int m, input int s);
        chk({tag, "_hh"}, 32'(ia.hh), 32'(h));
        chk({tag, "_mm"}, 32'(ia.mm), 32'(m));
        chk({tag, "_ss"}, 32'(ia.ss), 32'(s));
    endtask

    task automatic chk_b(input string tag, input int h, input int m, input int s);
        chk({tag, "_hh"}, 32'(ib.hh), 32'(h));
        chk({tag, "_mm"}, 32'(ib.mm), 32'(m));
        chk({tag, "_ss"}, 32'(ib.ss), 32'(s));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld_a(input int h, input int m, input int s);
        ia.ld_hh = 5'(h);
        ia.ld_mm = 6'(m);
        ia.ld_ss = 6'(s);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ia.run = 1'b1; ia.tick = 1'b0; ia.load = 1'b0; set_ld_a(0, 0, 0);
        ib.run = 1'b0; ib.tick = 1'b0; ib.load = 1'b0;
        ib.ld_hh = '0; ib.ld_mm = '0; ib.ld_ss = '0;
`ifdef TOD_ALARM_EN
        ia.al_en = 1'b0; ia.al_hh = '0; ia.al_mm = '0;
        ib.al_en = 1'b0; ib.al_hh = '0; ib.al_mm = '0;
`endif
        #3;
        chk_a("rst0", 0, 0, 0);
        chk("rst0_day", 32'(ia.day_tick), 0);
        chk("rst0_err", 32'(ia.load_err), 0);
        cyc();
        rst_n = 1'b1;

        // Count to 12:34:57, then reset asynchronously between edges
        ia.load = 1'b1; set_ld_a(12, 34, 56);
        cyc();
        ia.load = 1'b0;
        chk_a("ld123456", 12, 34, 56);
        ia.tick = 1'b1;
        cyc();
        ia.tick = 1'b0;
        chk_a("adv123457", 12, 34, 57);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 0, 0);
        chk("async_rst_day", 32'(ia.day_tick), 0);
        chk("async_rst_err", 32'(ia.load_err), 0);
        cyc();
        rst_n = 1'b1;

        // Single-second advance with minute carry
        ia.load = 1'b1; set_ld_a(0, 0, 58);
        cyc();
        ia.load = 1'b0;
        chk_a("ld000058", 0, 0, 58);
        ia.tick = 1'b1;
        cyc();
        chk_a("adv000059", 0, 0, 59);
        chk("adv000059_day", 32'(ia.day_tick), 0);
        cyc();
        ia.tick = 1'b0;
        chk_a("adv000100", 0, 1, 0);
        chk("adv000100_day", 32'(ia.day_tick), 0);

        // Midnight rollover
        ia.load = 1'b1; set_ld_a(23, 59, 59);
        cyc();
        ia.load = 1'b0;
        chk("ld235959_day", 32'(ia.day_tick), 0);
        ia.tick = 1'b1;
        cyc();
        ia.tick = 1'b0;
        chk_a("midnight", 0, 0, 0);
        chk("midnight_day", 32'(ia.day_tick), 1);
        cyc();
        chk("after_midnight_day", 32'(ia.day_tick), 0);
        chk_a("after_midnight", 0, 0, 0);

        // Loading 00:00:00 never raises day_tick
        ia.load = 1'b1; set_ld_a(0, 0, 0);
        cyc();
        ia.load = 1'b0;
        chk("ld000000_day", 32'(ia.day_tick), 0);

        // Rejected loads, with a coincident tick that must be discarded
        ia.load = 1'b1; set_ld_a(10, 0, 0);
        cyc();
        chk_a("ld100000", 10, 0, 0);
        set_ld_a(24, 0, 0); ia.tick = 1'b1;
        cyc();
        ia.load = 1'b0; ia.tick = 1'b0;
        chk_a("rej_hh24", 10, 0, 0);
        chk("rej_hh24_err", 32'(ia.load_err), 1);
        cyc();
        chk("rej_hh24_err_clr", 32'(ia.load_err), 0);
        ia.load = 1'b1; set_ld_a(10, 60, 0);
        cyc();
        ia.load = 1'b0;
        chk_a("rej_mm60", 10, 0, 0);
        chk("rej_mm60_err", 32'(ia.load_err), 1);
        ia.load = 1'b1; set_ld_a(5, 6, 7); ia.tick = 1'b1;
        cyc();
        ia.load = 1'b0; ia.tick = 1'b0;
        chk_a("ld050607", 5, 6, 7);
        chk("ld050607_err", 32'(ia.load_err), 0);
        cyc();
        chk_a("ld050607_hold", 5, 6, 7);

        // Load still works with run=0; ticks are ignored
        ia.run = 1'b0; ia.load = 1'b1; set_ld_a(1, 2, 3);
        cyc();
        ia.load = 1'b0; ia.tick = 1'b1;
        chk_a("run0_ld", 1, 2, 3);
        cyc();
        ia.tick = 1'b0; ia.run = 1'b1;
        chk_a("run0_tick", 1, 2, 3);

        // Prescaler of 4
        ib.run = 1'b1; ib.tick = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk_b("ps_3ticks", 0, 0, 0);
        cyc();
        chk_b("ps_4ticks", 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc();
        chk_b("ps_8ticks", 0, 0, 2);
        ib.run = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk_b("ps_run0", 0, 0, 2);
        ib.run = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        ib.tick = 1'b0; ib.load = 1'b1;
        cyc();
        ib.load = 1'b0; ib.tick = 1'b1;
        chk_b("ps_ld", 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc();
        chk_b("ps_ld_3ticks", 0, 0, 0);
        cyc();
        ib.tick = 1'b0;
        chk_b("ps_ld_4ticks", 0, 0, 1);

`ifdef TOD_ALARM_EN
        ia.al_en = 1'b1; ia.al_hh = 5'd7; ia.al_mm = 6'd30;
        ia.load = 1'b1; set_ld_a(7, 29, 59);
        cyc();
        ia.load = 1'b0;
        chk("al_ld_quiet", 32'(ia.alarm), 0);
        ia.tick = 1'b1;
        cyc();
        ia.tick = 1'b0;
        chk_a("al_073000", 7, 30, 0);
        chk("al_fire", 32'(ia.alarm), 1);
        cyc();
        chk("al_one_cycle", 32'(ia.alarm), 0);
        ia.load = 1'b1; set_ld_a(7, 30, 0);
        cyc();
        ia.load = 1'b0;
        chk("al_direct_load", 32'(ia.alarm), 0);
        ia.al_hh = 5'd0; ia.al_mm = 6'd0;
        ia.load = 1'b1; set_ld_a(23, 59, 59);
        cyc();
        ia.load = 1'b0; ia.tick = 1'b1;
        cyc();
        ia.tick = 1'b0;
        chk("al_midnight", 32'(ia.alarm), 1);
        chk("al_midnight_day", 32'(ia.day_tick), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
